controle_operacao: RTL
======================

CONTROLE_OPERACAO -- requirements
Module: controle_operacao

Interface
REQ-001 SHALL have parameter DEBOUNCE_CICLOS, default 16: consecutive stable cycles needed to accept a button level (board build: 1000000).
REQ-002 SHALL have parameter TIMEOUT_CICLOS, default 64: maximum cycles to wait for ALU completion.
REQ-003 SHALL have port clk, input, 1, the single system clock (rising edge).
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btn_prox, input, 1, raw active-low "next operation" key, asynchronous to clk.
REQ-006 SHALL have port btn_exec, input, 1, raw active-low "execute" key, asynchronous to clk.
REQ-007 SHALL have port ula_pronto, input, 1, ALU done strobe, synchronous to clk.
REQ-008 SHALL have port seletor, output, 3, current ALU operation code, also drives the HEX5 operation decoder.
REQ-009 SHALL have port ula_inicio, output, 1, one-cycle ALU start pulse.
REQ-010 SHALL have port ocupado, output, 1, high while waiting for the ALU.
REQ-011 SHALL have port erro, output, 1, sticky timeout flag.
REQ-012 SHALL have port contador_exec, output, 8, count of successfully completed operations.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CICLOS consecutive cycles; any bounce restarts the count.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced high-to-low transition; release SHALL generate no event.
REQ-015 Latency: with raw key low from edge N, the effect (seletor change or ula_inicio) SHALL be visible after edge N+3+DEBOUNCE_CICLOS.
REQ-016 FSM states: OCIOSO, AGUARDA.
REQ-017 OCIOSO, prox event: seletor SHALL increment modulo 8 (7 -> 0).
REQ-018 OCIOSO, exec event: ula_inicio SHALL pulse for exactly one cycle, erro SHALL clear, timeout counter SHALL clear, and the FSM SHALL go to AGUARDA.
REQ-019 OCIOSO, prox and exec events in the same cycle: exec SHALL win and seletor SHALL NOT change.
REQ-020 AGUARDA: seletor SHALL be frozen, and prox and exec events SHALL be discarded, not queued; ocupado SHALL be 1.
REQ-021 AGUARDA, ula_pronto=1: the FSM SHALL go to OCIOSO and contador_exec SHALL increment, saturating at 255.
REQ-022 AGUARDA: the timeout counter SHALL increment each cycle; when it reaches TIMEOUT_CICLOS without ula_pronto, erro SHALL set, the FSM SHALL go to OCIOSO, and contador_exec SHALL be unchanged.
REQ-023 ula_pronto and timeout in the same cycle: ula_pronto SHALL win (success, no erro).
REQ-024 ula_pronto while in OCIOSO SHALL be ignored.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst_n low SHALL immediately force the following, regardless of clock: seletor=0, ula_inicio=0, ocupado=0, erro=0, contador_exec=0, FSM=OCIOSO, all counters=0, synchronizers and debounced levels=1 (released).
REQ-027 Reset during AGUARDA SHALL abort the wait with no erro and no count increment.
REQ-028 A key held low across reset release SHALL produce exactly one event, after the full debounce latency.

Structure
REQ-029 State encodings (OCIOSO=0, AGUARDA=1) and operation width (3) SHALL live in shared package ula_pkg.
REQ-030 Synchronizer, debouncer and edge detect SHALL be sub-module debounce_botao, instantiated once per key.

Verification (DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=20)
REQ-031 Reset, then 3 clean prox presses, then 5 more -> seletor 0->1->2->3 after the first three, ending at 0 (wraps 7->0); each change occurs 7 edges after the key goes low.
REQ-032 prox bounce of 1,0,1,0 (1 cycle each), then steady low -> a single increment, timed from the last transition to low.
REQ-033 exec with seletor=5, ula_pronto pulsed 6 cycles after ula_inicio -> one ula_inicio pulse, ocupado high for 6 cycles, contador_exec 0->1, seletor stays 5 throughout; a prox press during the wait causes no change.
REQ-034 exec with ula_pronto never asserted -> erro=1 after 20 cycles in AGUARDA, ocupado=0, contador_exec unchanged; next exec clears erro.
REQ-035 prox and exec press events in the same cycle with seletor=2 -> ula_inicio pulses, seletor remains 2; ula_pronto coincident with cycle 20 -> no erro, count increments.
REQ-036 rst_n low mid-AGUARDA with seletor=6, contador_exec=3 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ula_pkg
// Brief   : Shared FSM encoding, operation width and small helpers for the
//           ALU operation controller.
// Rev     : 1.0 - initial release
// ============================================================================
package ula_pkg;

    localparam int OP_W   = 3;
    localparam int CONT_W = 8;

    typedef enum logic [0:0] {
        OCIOSO  = 1'b0,
        AGUARDA = 1'b1
    } estado_t;

    // Saturating increment for the completed-operation counter
    function automatic logic [CONT_W-1:0] inc_sat(input logic [CONT_W-1:0] v);
        return (v == {CONT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_botao.sv
`default_nettype none
// ============================================================================
// Module  : debounce_botao
// Brief   : 2-flop synchronizer, counting debouncer and press-edge pulse for
//           one active-low key.
// Rev     : 1.0 - initial release
// ============================================================================
module debounce_botao
    import ula_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pressao_o
);

    localparam int CNT_W = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic             sinc1_q;
    logic             sinc2_q;
    logic             nivel_q;
    logic             nivel_d;
    logic             nivel_ant_q;
    logic             pressao_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample matching the accepted level restarts the stability count
    always_comb begin
        cnt_d   = cnt_q;
        nivel_d = nivel_q;
        if (sinc2_q == nivel_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            nivel_d = sinc2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc1_q     <= 1'b1;
            sinc2_q     <= 1'b1;
            nivel_q     <= 1'b1;
            nivel_ant_q <= 1'b1;
            cnt_q       <= '0;
            pressao_q   <= 1'b0;
        end else begin
            sinc1_q     <= btn_i;
            sinc2_q     <= sinc1_q;
            nivel_q     <= nivel_d;
            cnt_q       <= cnt_d;
            nivel_ant_q <= nivel_q;
            pressao_q   <= nivel_ant_q & ~nivel_q;
        end
    end

    assign pressao_o = pressao_q;

endmodule
`default_nettype wire

// File: rtl/controle_operacao.sv
`default_nettype none
// ============================================================================
// Module  : controle_operacao
// Brief   : Key-driven ALU operation selector/launcher with completion
//           timeout, sticky error flag and saturating success counter.
// Rev     : 1.0 - initial release
// ============================================================================
module controle_operacao
    import ula_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int TIMEOUT_CICLOS  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_prox,
    input  logic              btn_exec,
    input  logic              ula_pronto,
    output logic [OP_W-1:0]   seletor,
    output logic              ula_inicio,
    output logic              ocupado,
    output logic              erro,
    output logic [CONT_W-1:0] contador_exec
);

    localparam int TMO_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TMO_W-1:0] TMO_ULTIMO = TMO_W'(TIMEOUT_CICLOS - 1);

    logic              ev_prox;
    logic              ev_exec;
    estado_t           estado_q;
    logic [OP_W-1:0]   seletor_q;
    logic              ula_inicio_q;
    logic              ocupado_q;
    logic              erro_q;
    logic [CONT_W-1:0] contador_q;
    logic [TMO_W-1:0]  tmo_q;

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_deb_prox (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_prox),
        .pressao_o (ev_prox)
    );

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_deb_exec (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_exec),
        .pressao_o (ev_exec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            seletor_q    <= '0;
            ula_inicio_q <= 1'b0;
            ocupado_q    <= 1'b0;
            erro_q       <= 1'b0;
            contador_q   <= '0;
            tmo_q        <= '0;
        end else begin
            ula_inicio_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    // exec has priority; a coincident prox press is dropped
                    if (ev_exec) begin
                        ula_inicio_q <= 1'b1;
                        erro_q       <= 1'b0;
                        tmo_q        <= '0;
                        ocupado_q    <= 1'b1;
                        estado_q     <= AGUARDA;
                    end else if (ev_prox) begin
                        seletor_q <= seletor_q + 1'b1;
                    end
                end
                AGUARDA: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (ula_pronto) begin
                        contador_q <= inc_sat(contador_q);
                        ocupado_q  <= 1'b0;
                        estado_q   <= OCIOSO;
                    end else if (tmo_q == TMO_ULTIMO) begin
                        erro_q    <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= OCIOSO;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign seletor       = seletor_q;
    assign ula_inicio    = ula_inicio_q;
    assign ocupado       = ocupado_q;
    assign erro          = erro_q;
    assign contador_exec = contador_q;

endmodule
`default_nettype wire
